// File: rtl/mmcm_drp_responder.sv
// Behavioural DRP slave for a modelled MMCM: 128x16 register file, fixed-latency
// handshake and a lock timer. Define DRP_LOCK_CHECK_EN to flag writes to a running MMCM.
module mmcm_drp_responder #(
  parameter int READY_LATENCY = 4,
  parameter int LOCK_DELAY    = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        drp_sel,
  input  logic        drp_wr,
  input  logic [6:0]  drp_addr,
  input  logic [15:0] drp_wdata,
  output logic [15:0] drp_rdata,
  output logic        drp_ready,
  input  logic        mmcm_rst,
  output logic        drp_locked,
  output logic        drp_err
);

  typedef enum logic [1:0] {T_IDLE, T_BUSY, T_RESP} txn_state_t;
  typedef enum logic [1:0] {L_RESET, L_WAIT_LOCK, L_LOCKED} lock_state_t;

  localparam logic [3:0]  LAT_M1   = 4'(READY_LATENCY - 1);
  localparam logic [11:0] LOCK_TGT = 12'(LOCK_DELAY);

  txn_state_t  txn_state_q, txn_state_d;
  lock_state_t lock_state_q, lock_state_d;
  logic [3:0]  lat_cnt_q, lat_cnt_d;
  logic [11:0] lock_cnt_q, lock_cnt_d;
  logic [6:0]  addr_q, addr_d;
  logic        wr_q, wr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [15:0] mem_q [128];

  logic complete;
  logic mem_we;
  logic lock_restart;

  // The transaction finishes on the edge that leaves BUSY; RESP is the cycle after it.
  assign complete = (txn_state_q == T_BUSY) && (lat_cnt_q == 4'd0);
  assign mem_we   = complete && wr_q;

`ifdef DRP_LOCK_CHECK_EN
  assign lock_restart = mem_we && !mmcm_rst;
`else
  assign lock_restart = 1'b0;
`endif

  always_comb begin
    txn_state_d = txn_state_q;
    lat_cnt_d   = lat_cnt_q;
    addr_d      = addr_q;
    wr_d        = wr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    case (txn_state_q)
      T_IDLE, T_RESP: begin
        if (drp_sel) begin
          txn_state_d = T_BUSY;
          lat_cnt_d   = LAT_M1;
          addr_d      = drp_addr;
          wr_d        = drp_wr;
          wdata_d     = drp_wdata;
        end else begin
          txn_state_d = T_IDLE;
        end
      end
      T_BUSY: begin
        if (drp_sel) begin
          err_d = 1'b1;
        end
        if (lat_cnt_q == 4'd0) begin
          txn_state_d = T_RESP;
          if (!wr_q) begin
            rdata_d = mem_q[addr_q];
          end
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end
      default: txn_state_d = T_IDLE;
    endcase
    if (lock_restart) begin
      err_d = 1'b1;
    end
  end

  // mmcm_rst dominates everything, including a write-triggered restart.
  always_comb begin
    lock_state_d = lock_state_q;
    lock_cnt_d   = lock_cnt_q;
    if (mmcm_rst) begin
      lock_state_d = L_RESET;
      lock_cnt_d   = 12'd0;
    end else if (lock_restart) begin
      lock_state_d = L_WAIT_LOCK;
      lock_cnt_d   = 12'd0;
    end else begin
      case (lock_state_q)
        L_RESET: begin
          lock_state_d = L_WAIT_LOCK;
          lock_cnt_d   = 12'd0;
        end
        L_WAIT_LOCK: begin
          lock_cnt_d = lock_cnt_q + 12'd1;
          if (lock_cnt_q + 12'd1 == LOCK_TGT) begin
            lock_state_d = L_LOCKED;
          end
        end
        L_LOCKED: lock_state_d = L_LOCKED;
        default:  lock_state_d = L_RESET;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      txn_state_q  <= T_IDLE;
      lock_state_q <= L_RESET;
      lat_cnt_q    <= 4'd0;
      lock_cnt_q   <= 12'd0;
      addr_q       <= 7'd0;
      wr_q         <= 1'b0;
      wdata_q      <= 16'd0;
      rdata_q      <= 16'd0;
      err_q        <= 1'b0;
    end else begin
      txn_state_q  <= txn_state_d;
      lock_state_q <= lock_state_d;
      lat_cnt_q    <= lat_cnt_d;
      lock_cnt_q   <= lock_cnt_d;
      addr_q       <= addr_d;
      wr_q         <= wr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  // Whole-array clear in a single reset cycle, so the array lives in flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 128; i++) begin
        mem_q[i] <= 16'd0;
      end
    end else if (mem_we) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  assign drp_rdata  = rdata_q;
  assign drp_ready  = (txn_state_q == T_RESP);
  assign drp_err    = err_q;
  assign drp_locked = (lock_state_q == L_LOCKED);

endmodule

// File: tb/tb_mmcm_drp_responder.sv
// Testbench for mmcm_drp_responder: directed scenarios plus random traffic, every
// cycle compared against an event-time reference model.
module tb_mmcm_drp_responder;

  localparam int LAT = 4;
  localparam int LKD = 64;
`ifdef DRP_LOCK_CHECK_EN
  localparam bit LCK = 1'b1;
`else
  localparam bit LCK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        drp_sel;
  logic        drp_wr;
  logic [6:0]  drp_addr;
  logic [15:0] drp_wdata;
  logic [15:0] drp_rdata;
  logic        drp_ready;
  logic        mmcm_rst;
  logic        drp_locked;
  logic        drp_err;

  mmcm_drp_responder #(.READY_LATENCY(LAT), .LOCK_DELAY(LKD)) dut (
    .clk        (clk),
    .rst        (rst),
    .drp_sel    (drp_sel),
    .drp_wr     (drp_wr),
    .drp_addr   (drp_addr),
    .drp_wdata  (drp_wdata),
    .drp_rdata  (drp_rdata),
    .drp_ready  (drp_ready),
    .mmcm_rst   (mmcm_rst),
    .drp_locked (drp_locked),
    .drp_err    (drp_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: absolute edge numbers instead of state machines.
  logic [15:0] m_mem [128];
  logic [15:0] m_rdata;
  logic        m_ready;
  logic        m_err;
  logic        m_locked;
  logic        m_pend;
  logic        m_wr;
  logic [6:0]  m_addr;
  logic [15:0] m_wdata;
  int          m_done;
  int          m_low_since;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_step();
    bit busy;
    bit restart;
    cyc++;
    restart = 1'b0;
    if (rst) begin
      for (int i = 0; i < 128; i++) m_mem[i] = 16'd0;
      m_rdata     = 16'd0;
      m_ready     = 1'b0;
      m_err       = 1'b0;
      m_pend      = 1'b0;
      m_low_since = -1;
    end else begin
      busy    = m_pend;
      m_ready = 1'b0;
      if (m_pend && cyc == m_done) begin
        m_ready = 1'b1;
        m_pend  = 1'b0;
        if (m_wr) begin
          m_mem[m_addr] = m_wdata;
          if (LCK && !mmcm_rst) begin
            m_err   = 1'b1;
            restart = 1'b1;
          end
        end else begin
          m_rdata = m_mem[m_addr];
        end
        $display("txn cyc=%0d %s addr=%02h data=%04h", cyc, m_wr ? "WR" : "RD",
                 m_addr, m_wr ? m_wdata : m_rdata);
      end
      if (drp_sel) begin
        if (busy) begin
          m_err = 1'b1;
        end else begin
          m_pend  = 1'b1;
          m_done  = cyc + LAT;
          m_wr    = drp_wr;
          m_addr  = drp_addr;
          m_wdata = drp_wdata;
        end
      end
      if (mmcm_rst) m_low_since = -1;
      else if (restart || m_low_since < 0) m_low_since = cyc;
    end
    m_locked = (m_low_since >= 0) && (cyc - m_low_since >= LKD);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("ready",  32'(drp_ready),  32'(m_ready));
    chk("rdata",  32'(drp_rdata),  32'(m_rdata));
    chk("err",    32'(drp_err),    32'(m_err));
    chk("locked", 32'(drp_locked), 32'(m_locked));
  endtask

  task automatic issue(input logic wr, input logic [6:0] addr, input logic [15:0] data);
    drp_sel   = 1'b1;
    drp_wr    = wr;
    drp_addr  = addr;
    drp_wdata = data;
    tick();
    drp_sel = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!drp_ready && n < 40);
    chk("ready_timeout", 32'(drp_ready), 32'd1);
  endtask

  task automatic wait_lock(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!drp_locked && n < 300);
    chk("lock_timeout", 32'(drp_locked), 32'd1);
  endtask

  task automatic count_ready(input int cycles, output int pulses);
    pulses = 0;
    repeat (cycles) begin
      tick();
      if (drp_ready) pulses++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int pulses;
    rst = 1'b1; mmcm_rst = 1'b1; drp_sel = 1'b0; drp_wr = 1'b0;
    drp_addr = 7'd0; drp_wdata = 16'd0;
    repeat (3) tick();
    chk("rst_rdata",  32'(drp_rdata),  32'd0);
    chk("rst_locked", 32'(drp_locked), 32'd0);
    rst = 1'b0; mmcm_rst = 1'b0;

    // Lock timing, then a restart 30 cycles into the wait.
    tick();
    wait_lock(n);
    chk("lock_lat", 32'(n), 32'(LKD));
    mmcm_rst = 1'b1; tick(); mmcm_rst = 1'b0;
    tick();
    repeat (29) tick();
    mmcm_rst = 1'b1; tick(); mmcm_rst = 1'b0;
    tick();
    wait_lock(n);
    chk("relock_lat", 32'(n), 32'(LKD));

    // Read latency.
    issue(1'b1, 7'h08, 16'h1234);
    wait_ready(n);
    chk("wr_lat", 32'(n), 32'(LAT));
    issue(1'b0, 7'h08, 16'h0000);
    wait_ready(n);
    chk("rd_lat", 32'(n), 32'(LAT));
    chk("rd08", 32'(drp_rdata), 32'h1234);

    // Back-to-back: new request on the ready cycle.
    issue(1'b1, 7'h08, 16'hBEEF);
    wait_ready(n);
    issue(1'b0, 7'h08, 16'h0000);
    wait_ready(n);
    chk("b2b_lat",  32'(n), 32'(LAT));
    chk("b2b_data", 32'(drp_rdata), 32'hBEEF);
    chk("b2b_err",  32'(drp_err), 32'(LCK));

    // Overlapping request two cycles after acceptance.
    rst = 1'b1; tick(); rst = 1'b0;
    issue(1'b0, 7'h08, 16'h0000);
    tick();
    issue(1'b0, 7'h09, 16'h0000);
    wait_ready(n);
    chk("ovl_lat", 32'(n), 32'(LAT - 2));
    count_ready(10, pulses);
    chk("ovl_pulses", 32'(pulses), 32'd0);
    chk("ovl_err", 32'(drp_err), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("err_clr", 32'(drp_err), 32'd0);

    // Reset one cycle after a write is accepted.
    issue(1'b1, 7'h10, 16'hAAAA);
    rst = 1'b1; tick(); rst = 1'b0;
    count_ready(8, pulses);
    chk("abort_pulses", 32'(pulses), 32'd0);
    issue(1'b0, 7'h10, 16'h0000);
    wait_ready(n);
    chk("abort_rd", 32'(drp_rdata), 32'h0000);

    // Write to a locked, running MMCM.
    wait_lock(n);
    issue(1'b1, 7'h20, 16'h0001);
    wait_ready(n);
    chk("lc_locked", 32'(drp_locked), 32'(!LCK));
    chk("lc_err",    32'(drp_err),    32'(LCK));
`ifdef DRP_LOCK_CHECK_EN
    wait_lock(n);
    chk("lc_relock", 32'(n), 32'(LKD));
`else
    repeat (80) tick();
    chk("lc_hold", 32'(drp_locked), 32'd1);
`endif

    // Random traffic.
    for (int k = 0; k < 2000; k++) begin
      drp_sel   = ($urandom_range(0, 99) < 30);
      drp_wr    = 1'($urandom_range(0, 1));
      drp_addr  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(0, 7));
      drp_wdata = 16'($urandom);
      if (mmcm_rst) mmcm_rst = ($urandom_range(0, 99) >= 20);
      else          mmcm_rst = ($urandom_range(0, 999) < 5);
      rst = ($urandom_range(0, 999) < 3);
      tick();
    end
    rst = 1'b0; drp_sel = 1'b0;
    repeat (8) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mmcm_drp_responder.md
MMCM_DRP_RESPONDER -- requirements
Module: mmcm_drp_responder

Interface
REQ-001 SHALL have parameter READY_LATENCY, default 4, cycles from accepted request to drp_ready; legal range 1..15.
REQ-002 SHALL have parameter LOCK_DELAY, default 64, cycles of mmcm_rst low before drp_locked rises; legal range 1..4095.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port drp_sel  input  1  request strobe, one cycle per transaction.
REQ-006 SHALL have port drp_wr  input  1  1 = write, 0 = read; sampled with drp_sel.
REQ-007 SHALL have port drp_addr  input  7  register address; sampled with drp_sel.
REQ-008 SHALL have port drp_wdata  input  16  write data; sampled with drp_sel.
REQ-009 SHALL have port drp_rdata  output  16  read data; valid when drp_ready is high after a read.
REQ-010 SHALL have port drp_ready  output  1  one-cycle completion pulse.
REQ-011 SHALL have port mmcm_rst  input  1  modelled MMCM reset, active-high.
REQ-012 SHALL have port drp_locked  output  1  modelled MMCM lock.
REQ-013 SHALL have port drp_err  output  1  sticky protocol-error flag.

Function
REQ-014 SHALL hold a 128 x 16 register array addressed by drp_addr.
REQ-015 SHALL run a transaction FSM with states IDLE -> BUSY -> RESP -> IDLE.
REQ-016 SHALL accept drp_sel=1 in IDLE or RESP, latch addr/wr/wdata, and enter BUSY.
REQ-017 SHALL assert drp_ready exactly READY_LATENCY cycles after the accepting edge, for one cycle, in RESP.
REQ-018 SHALL, for a write, update the array on the drp_ready cycle; drp_rdata SHALL be unchanged.
REQ-019 SHALL, for a read, load drp_rdata with the array content on the drp_ready cycle and hold it until the next read completes.
REQ-020 SHALL treat drp_sel=1 in the RESP cycle as a new accepted request (back-to-back, no idle cycle).
REQ-021 SHALL ignore drp_sel=1 while in BUSY and set drp_err; drp_err SHALL clear only on rst.
REQ-022 SHALL run a lock FSM with states RESET, WAIT_LOCK, LOCKED and a 12-bit counter.
REQ-023 SHALL enter RESET with drp_locked=0 and the counter cleared on any cycle mmcm_rst=1, from any state.
REQ-024 SHALL move RESET -> WAIT_LOCK on the first cycle mmcm_rst=0, then increment the counter once per cycle.
REQ-025 SHALL move WAIT_LOCK -> LOCKED and drive drp_locked=1 when the counter reaches LOCK_DELAY, and hold it until mmcm_rst rises.
REQ-026 SHALL complete an in-flight DRP transaction normally regardless of mmcm_rst.

Reset
REQ-027 SHALL, on rst, clear all array entries to 0x0000, drp_rdata=0, drp_ready=0, drp_err=0, drp_locked=0, transaction FSM=IDLE, lock FSM=RESET, counter=0.
REQ-028 SHALL abort an in-flight transaction on rst with no drp_ready pulse and no array update.

Configuration
REQ-029 SHALL honour macro DRP_LOCK_CHECK_EN: when defined, a write that completes while mmcm_rst=0 SHALL set drp_err and force the lock FSM to WAIT_LOCK with the counter cleared (drp_locked=0); the array update still occurs.
REQ-030 SHALL, without DRP_LOCK_CHECK_EN, leave lock state and drp_err unaffected by writes.

Verification
REQ-031 SHALL verify read latency: write 0x1234 to addr 0x08, then read 0x08 -> drp_ready exactly 4 cycles after each drp_sel, drp_rdata=0x1234.
REQ-032 SHALL verify back-to-back: drp_sel asserted on the drp_ready cycle for read of 0x08 after write of 0xBEEF -> second drp_ready 4 cycles later, drp_rdata=0xBEEF, drp_err=0.
REQ-033 SHALL verify overlap error: drp_sel asserted 2 cycles after an accepted request -> one drp_ready only, drp_err=1 until rst.
REQ-034 SHALL verify lock timing with LOCK_DELAY=64: mmcm_rst deasserted -> drp_locked rises after 64 cycles; mmcm_rst pulsed at cycle 30 -> count restarts, no early lock.
REQ-035 SHALL verify reset mid-transaction: rst one cycle after a write of 0xAAAA to 0x10 is accepted -> no drp_ready, later read of 0x10 returns 0x0000.
REQ-036 SHALL verify DRP_LOCK_CHECK_EN: write 0x0001 while locked with mmcm_rst=0 -> drp_locked=0, drp_err=1 after completion, relock 64 cycles later; with the macro undefined -> drp_locked stays 1, drp_err=0.
